// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: streams N words into addresses 0..N-1, then
// verifies a trailing checksum word before raising ready for the core.
module imem_program_loader #(
  parameter int SIZE_IM = 32,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [5:0]        load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ready,
  output logic              busy,
  output logic              error,
  output logic [5:0]        words_loaded,
  output logic [2:0]        state_dbg
);

  // Handshake: a stream beat transfers on a rising clk edge where in_valid && in_ready.
  // in_ready is registered and high only in LOAD and CHECK; in_valid may drop at any time.

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic [5:0] MAX_LEN = 6'(SIZE_IM);

  logic [2:0]        state;
  logic [5:0]        count;
  logic [5:0]        len_q;
  logic [DATA_W-1:0] sum;
  logic              beat;
  logic              len_ok;
  logic [DATA_W-1:0] sum_next;

  assign beat         = in_valid && in_ready;
  assign len_ok       = (load_len != 6'd0) && (load_len <= MAX_LEN);
  assign sum_next     = sum + in_data;
  assign words_loaded = count;
  assign state_dbg    = state;

  // Outputs are updated alongside the state so each one is a plain register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      len_q     <= '0;
      sum       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start) begin
            ready <= 1'b0;
            if (len_ok) begin
              state    <= ST_LOAD;
              count    <= '0;
              sum      <= '0;
              len_q    <= load_len;
              error    <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(count);
            mem_wdata <= in_data;
            sum       <= sum_next;
            count     <= count + 6'd1;
            if (count == len_q - 6'd1) begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (beat) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (sum_next == '0) begin
              state <= ST_DONE;
              ready <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: expected memory writes are queued as beats are
// driven and compared as write strobes appear.
module tb_imem_program_loader;

  logic        clk;
  logic        reset_n;
  logic        load_start;
  logic [5:0]  load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        ready;
  logic        busy;
  logic        error;
  logic [5:0]  words_loaded;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [31:0] exp_q[$];

  imem_program_loader #(.SIZE_IM(32), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ready(ready), .busy(busy),
    .error(error), .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {in_ready, mem_we, mem_addr, mem_wdata, ready, busy, error, words_loaded}, '0);
  endtask

  // scoreboard: every write strobe must match the oldest queued {addr, data}
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mem_we === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks, all entered and left on a falling edge
  task automatic start_load(input logic [5:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = $urandom_range(0, 63);
  endtask

  task automatic send_word(input logic [15:0] data, input bit is_prog, input logic [15:0] addr);
    int n = 0;
    in_valid = 1'b1;
    in_data  = data;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else if (is_prog) begin
      exp_q.push_back({addr, data});
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 65535);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // full program of len words plus its checksum; gap cycles idle between beats
  task automatic load_program(input int len, input bit good_sum, input int gap);
    logic [15:0] sum = '0;
    logic [15:0] w;
    for (int i = 0; i < len; i++) begin
      w = $urandom_range(0, 65535);
      sum += w;
      send_word(w, 1'b1, 16'(i));
      idle(gap);
    end
    send_word(good_sum ? 16'(-sum) : 16'(~(-sum)), 1'b0, 16'd0);
  endtask

  int w0;
  logic [15:0] prog[3];

  initial begin
    load_start = 1'b0;
    load_len   = 6'd0;
    in_valid   = 1'b0;
    in_data    = 16'd0;
    reset_n    = 1'b1;
    prog[0] = 16'h2105; prog[1] = 16'h2203; prog[2] = 16'h4312;

    // 1: async reset with random inputs, checked before any clock edge
    #1;
    load_start = 1'($urandom_range(0, 1));
    load_len   = $urandom_range(0, 63);
    in_valid   = 1'($urandom_range(0, 1));
    in_data    = $urandom_range(0, 65535);
    reset_n    = 1'b0;
    #2;
    check_all_zero("reset");
    check("reset_state", state_dbg, 0);
    load_start = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // 2: directed program with correct checksum 16'h79E6
    start_load(6'd3);
    check("t2_busy", busy, 1);
    check("t2_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1, 16'(i));
    check("t2_ready_before_sum", ready, 0);
    check("t2_busy_check", busy, 1);
    send_word(16'h79E6, 1'b0, 16'd0);
    check("t2_ready", ready, 1);
    check("t2_error", error, 0);
    check("t2_busy_done", busy, 0);
    check("t2_in_ready_done", in_ready, 0);
    check("t2_words", words_loaded, 3);
    idle(2);
    check("t2_ready_held", ready, 1);

    // 3: same program, bad checksum
    start_load(6'd3);
    check("t3_ready_cleared", ready, 0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1, 16'(i));
    send_word(16'h0000, 1'b0, 16'd0);
    check("t3_error", error, 1);
    check("t3_ready", ready, 0);
    check("t3_words", words_loaded, 3);

    // 4: gaps between beats
    w0 = writes;
    start_load(6'd4);
    check("t4_error_cleared", error, 0);
    load_program(4, 1'b1, 3);
    check("t4_writes", writes - w0, 4);
    check("t4_ready", ready, 1);
    check("t4_words", words_loaded, 4);

    // 5: illegal lengths
    w0 = writes;
    start_load(6'd0);
    check("t5_len0_error", error, 1);
    check("t5_len0_ready", ready, 0);
    check("t5_len0_in_ready", in_ready, 0);
    start_load(6'd33);
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    check("t5_len33_error", error, 1);
    check("t5_len33_in_ready", in_ready, 0);
    check("t5_len33_busy", busy, 0);
    check("t5_writes", writes - w0, 0);

    // maximum length boundary
    start_load(6'd32);
    load_program(32, 1'b1, 0);
    check("max_ready", ready, 1);
    check("max_words", words_loaded, 32);

    // 6: reset in the middle of a load
    start_load(6'd4);
    send_word(16'h1111, 1'b1, 16'd0);
    send_word(16'h2222, 1'b1, 16'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    start_load(6'd2);
    load_program(2, 1'b1, 0);
    check("t6_ready", ready, 1);
    check("t6_words", words_loaded, 2);

    // 7: restart from DONE, and load_start ignored while loading
    start_load(6'd1);
    check("t7_ready_fall", ready, 0);
    check("t7_busy", busy, 1);
    start_load(6'd0);
    check("t7_ignored_error", error, 0);
    check("t7_ignored_busy", busy, 1);
    load_program(1, 1'b1, 0);
    check("t7_ready", ready, 1);
    check("t7_words", words_loaded, 1);

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
